serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor computing x - y - borrow_in one bit per clock,
//   LSB first. One capture edge plus WIDTH RUN edges per operation; results
//   are published together on the last RUN edge and held until the next
//   completion.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request a new operation (ignored while busy)
//   x, y        in   minuend / subtrahend [WIDTH]
//   borrow_in   in   incoming borrow
//   busy        out  high in RUN
//   done        out  one-cycle pulse, results valid
//   difference  out  x - y - borrow_in mod 2^WIDTH
//   borrow_out  out  borrow out of the MSB
//   overflow    out  two's-complement signed overflow
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic             r_br, r_x_msb, r_y_msb;
    logic [CW-1:0]    r_cnt;

    logic             w_last, w_capture, w_d, w_br_next;
    logic [WIDTH-1:0] w_res;

    // Current bit pair always sits in bit 0 of the shifting operand copies.
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res     = {w_d, r_res[WIDTH-1:1]};
    assign w_last    = (r_cnt == LAST);
    assign w_capture = start && (r_state != S_RUN);

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_br       <= 1'b0;
            r_x_msb    <= 1'b0;
            r_y_msb    <= 1'b0;
            r_cnt      <= '0;
            difference <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else if (w_capture) begin
            r_a     <= x;
            r_b     <= y;
            r_br    <= borrow_in;
            r_res   <= '0;
            r_cnt   <= '0;
            // Operand MSBs are kept aside because r_a/r_b are consumed by shifting.
            r_x_msb <= x[WIDTH-1];
            r_y_msb <= y[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_res <= w_res;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                // w_d is the result MSB on the final bit.
                difference <= w_res;
                borrow_out <= w_br_next;
                overflow   <= (r_x_msb != r_y_msb) && (w_d != r_x_msb);
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
module tb_serial_subtractor;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic [W-1:0] x = '0, y = '0;
    logic         borrow_in = 1'b0;
    logic         busy, done, borrow_out, overflow;
    logic [W-1:0] difference;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .borrow_in(borrow_in), .busy(busy), .done(done),
        .difference(difference), .borrow_out(borrow_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: full-width arithmetic, completion WIDTH edges after capture.
    int           m_left = 0;
    logic         m_done = 1'b0, m_bo = 1'b0, m_ov = 1'b0;
    logic [W-1:0] m_diff = '0, p_x = '0, p_y = '0;
    logic [W:0]   p_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_done <= 1'b0; m_diff <= '0; m_bo <= 1'b0; m_ov <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_diff <= p_res[W-1:0];
                m_bo   <= p_res[W];
                m_ov   <= (p_x[W-1] != p_y[W-1]) && (p_res[W-1] != p_x[W-1]);
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_left <= W;
                p_x    <= x;
                p_y    <= y;
                p_res  <= {1'b0, x} - {1'b0, y} - (W+1)'(borrow_in);
            end
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_busy", 32'(busy), 32'(m_left != 0));
            chk("cmp_done", 32'(done), 32'(m_done));
            chk("cmp_diff", 32'(difference), 32'(m_diff));
            chk("cmp_bo",   32'(borrow_out), 32'(m_bo));
            chk("cmp_ov",   32'(overflow), 32'(m_ov));
        end
    end

    // Start one operation from idle, wait for done, check literal results.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic bi,
                         input logic [W-1:0] ed, input logic eb, input logic eo, input string nm);
        int n, busy_n;
        @(negedge clk);
        x = xa; y = ya; borrow_in = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 0; busy_n = 0;
        while (!done && n < 20) begin
            if (busy) busy_n++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd4);
        chk({nm, "_busycyc"}, 32'(busy_n), 32'd4);
        chk({nm, "_diff"}, 32'(difference), 32'(ed));
        chk({nm, "_bo"}, 32'(borrow_out), 32'(eb));
        chk({nm, "_ov"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(difference), 32'd0);
        chk("rst_bo_ov", 32'({borrow_out, overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        do_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, "basic");
        do_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0, "neg");
        do_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, "ovf");
        do_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, "borrow");
        do_op(4'b0111, 4'b1111, 1'b1, 4'b0111, 1'b1, 1'b0, "mix");
        do_op(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, "ovf2");

        // Start and operand changes during RUN must be ignored.
        @(negedge clk);
        x = 4'b0101; y = 4'b0011; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);                       // after edge 1
        start = 1'b0;
        @(negedge clk);                       // after edge 2
        x = 4'b1111; y = 4'b0000; start = 1'b1;
        @(negedge clk);                       // after edge 3
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        chk("ign_latency", 32'(n), 32'd2);
        chk("ign_diff", 32'(difference), 32'd2);
        chk("ign_bo_ov", 32'({borrow_out, overflow}), 32'd0);

        // Back-to-back start in the DONE cycle.
        x = 4'b0111; y = 4'b0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_hold_diff", 32'(difference), 32'd2);
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        chk("b2b_latency", 32'(n), 32'd4);
        chk("b2b_diff", 32'(difference), 32'd6);

        // Reset in the middle of a run.
        @(negedge clk);
        x = 4'b1001; y = 4'b0011; start = 1'b1;
        @(posedge clk);                       // edge 1
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);                       // edge 2
        @(posedge clk);                       // edge 3
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_diff", 32'(difference), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin @(negedge clk); if (done) n++; end
        chk("mid_rst_no_done", 32'(n), 32'd0);
        do_op(4'b0110, 4'b0010, 1'b0, 4'b0100, 1'b0, 1'b0, "post_rst");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
